// File: rtl/serial_rx_lr_pkg.sv
// Shared widths, defaults and FSM encoding for the stereo serial receiver.
// Optional sleep detector is enabled with SERIAL_RX_SLEEP_EN.
package serial_rx_lr_pkg;

  localparam int DATA_W   = 16;
  localparam int ZERO_CNT = 800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serial_rx_lr_if.sv
// Frame/data inputs and word/strobe outputs of the stereo receiver.
// The sleep signal exists only when SERIAL_RX_SLEEP_EN is defined.
interface serial_rx_lr_if #(
  parameter int DATA_W = serial_rx_lr_pkg::DATA_W
);

  logic              Frame;
  logic              InputL;
  logic              InputR;
  logic [DATA_W-1:0] sampleL;
  logic [DATA_W-1:0] sampleR;
  logic              sign_statusL;
  logic              sign_statusR;
  logic              sync_err;
`ifdef SERIAL_RX_SLEEP_EN
  logic              sleep;

  modport master (
    output Frame, InputL, InputR,
    input  sampleL, sampleR,
    input  sign_statusL, sign_statusR,
    input  sync_err, sleep
  );

  modport slave (
    input  Frame, InputL, InputR,
    output sampleL, sampleR,
    output sign_statusL, sign_statusR,
    output sync_err, sleep
  );
`else
  modport master (
    output Frame, InputL, InputR,
    input  sampleL, sampleR,
    input  sign_statusL, sign_statusR,
    input  sync_err
  );

  modport slave (
    input  Frame, InputL, InputR,
    output sampleL, sampleR,
    output sign_statusL, sign_statusR,
    output sync_err
  );
`endif

endinterface

// File: rtl/serial_rx_lr_shift16.sv
// Per-channel MSB-first shift register with synchronous clear.
// nxt is the word as it will be after this edge's shift.
module serial_shift16
  import serial_rx_lr_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         Sclk,
  input  logic         Reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] nxt
);

  logic [W-1:0] sh_q;

  assign nxt = {sh_q[W-2:0], din};

  always_ff @(posedge Sclk) begin
    if (!Reset_n || clr) begin
      sh_q <= '0;
    end else if (en) begin
      sh_q <= nxt;
    end
  end

endmodule

// File: rtl/serial_rx_lr.sv
// Stereo serial-input front end: frame-synced 16-bit L/R deserialiser.
// Define SERIAL_RX_SLEEP_EN to add the all-zero-frame sleep output.
module serial_rx_lr
  import serial_rx_lr_pkg::*;
#(
  parameter int ZW_MAX   = DATA_W,
  parameter int ZERO_CNT = serial_rx_lr_pkg::ZERO_CNT
) (
  input  logic          Sclk,
  input  logic          Reset_n,
  serial_rx_lr_if.slave bus
);

  localparam int CNT_W = $clog2(ZW_MAX);

  rx_state_t        state_q;
  rx_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sh_en;
  logic             sh_clr;
  logic             load;
  logic             err;
  logic [ZW_MAX-1:0] nxtL;
  logic [ZW_MAX-1:0] nxtR;

  serial_shift16 #(.W(ZW_MAX)) u_shL (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .clr     (sh_clr),
    .en      (sh_en),
    .din     (bus.InputL),
    .nxt     (nxtL)
  );

  serial_shift16 #(.W(ZW_MAX)) u_shR (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .clr     (sh_clr),
    .en      (sh_en),
    .din     (bus.InputR),
    .nxt     (nxtR)
  );

  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_en   = 1'b0;
    sh_clr  = 1'b0;
    load    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Frame) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        // Frame mid-word wins even on the last bit: word is aborted
        if (bus.Frame) begin
          err    = 1'b1;
          cnt_d  = '0;
          sh_clr = 1'b1;
        end else begin
          sh_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ZW_MAX - 1)) begin
            state_d = DONE;
            load    = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.Frame) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs register at the last-bit edge so they are live in DONE
  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      bus.sampleL      <= '0;
      bus.sampleR      <= '0;
      bus.sign_statusL <= 1'b0;
      bus.sign_statusR <= 1'b0;
      bus.sync_err     <= 1'b0;
    end else begin
      bus.sign_statusL <= load;
      bus.sign_statusR <= load;
      bus.sync_err     <= err;
      if (load) begin
        bus.sampleL <= nxtL;
        bus.sampleR <= nxtR;
      end
    end
  end

`ifdef SERIAL_RX_SLEEP_EN
  localparam int ZC_W = $clog2(ZERO_CNT + 1);

  logic [ZC_W-1:0] zc_q;
  logic [ZC_W-1:0] zc_inc;

  assign zc_inc = (zc_q == ZC_W'(ZERO_CNT)) ? zc_q : zc_q + 1'b1;

  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      zc_q      <= '0;
      bus.sleep <= 1'b0;
    end else if (load) begin
      if (nxtL == '0 && nxtR == '0) begin
        zc_q      <= zc_inc;
        bus.sleep <= (zc_inc == ZC_W'(ZERO_CNT));
      end else begin
        zc_q      <= '0;
        bus.sleep <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_rx_lr.sv
// Scoreboard bench for serial_rx_lr: stimulus pushes expected words and
// error pulses; a negedge monitor pops and compares them.
module tb_serial_rx_lr;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  logic Sclk;
  logic Reset_n;
  int   cyc;
  int   n_pass;
  int   n_tot;
  bit   run;
  bit   abort_pend;

  exp_t exp_q[$];
  int   err_q[$];

  serial_rx_lr_if #(.DATA_W(W)) bus ();

  serial_rx_lr #(.ZW_MAX(W), .ZERO_CNT(4)) dut (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  initial cyc = 0;
  always @(posedge Sclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    exp_t e;
    e.l   = l;
    e.r   = r;
    e.cyc = cyc + 17;
    exp_q.push_back(e);
    if (abort_pend) begin
      err_q.push_back(cyc + 1);
      abort_pend = 1'b0;
    end
    bus.Frame  = 1'b1;
    bus.InputL = 1'($urandom);
    bus.InputR = 1'($urandom);
    tick();
    bus.Frame = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      bus.InputL = l[i];
      bus.InputR = r[i];
      tick();
    end
    bus.InputL = 1'b0;
    bus.InputR = 1'b0;
  endtask

  task automatic send_partial(input int nbits, input bit resync);
    bus.Frame = 1'b1;
    tick();
    bus.Frame = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.InputL = 1'($urandom);
      bus.InputR = 1'($urandom);
      tick();
    end
    abort_pend = resync;
  endtask

  always @(negedge Sclk) begin
    if (run) begin
      if (bus.sign_statusL || bus.sign_statusR) begin
        exp_t e;
        chk("strobe_pair", 32'(bus.sign_statusR), 32'(bus.sign_statusL));
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sampleL", 32'(bus.sampleL), 32'(e.l));
          chk("sampleR", 32'(bus.sampleR), 32'(e.r));
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.sync_err) begin
        if (err_q.size() == 0) chk("unexpected_sync_err", 32'(cyc), 32'hFFFF_FFFF);
        else chk("sync_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end
    end
  end

  initial begin
    n_pass     = 0;
    n_tot      = 0;
    run        = 1'b0;
    abort_pend = 1'b0;
    Reset_n    = 1'b0;
    bus.Frame  = 1'b0;
    bus.InputL = 1'b0;
    bus.InputR = 1'b0;

    // reset with activity on the inputs
    for (int i = 0; i < 3; i++) begin
      bus.InputL = 1'($urandom);
      bus.InputR = 1'($urandom);
      bus.Frame  = (i == 1);
      tick();
      chk("rst_sampleL", 32'(bus.sampleL), 32'h0);
      chk("rst_sampleR", 32'(bus.sampleR), 32'h0);
      chk("rst_strobes", {30'b0, bus.sign_statusL, bus.sign_statusR}, 32'h0);
      chk("rst_sync_err", 32'(bus.sync_err), 32'h0);
    end
    bus.Frame  = 1'b0;
    bus.InputL = 1'b0;
    bus.InputR = 1'b0;
    Reset_n    = 1'b1;
    run        = 1'b1;
    repeat (2) tick();

    send_frame(16'h8001, 16'h7FFE);
    repeat (3) tick();

    // back-to-back: second Frame lands in the DONE cycle
    send_frame(16'h1234, 16'hFEDC);
    send_frame(16'hA5C3, 16'h0F0F);
    repeat (2) tick();

    // resync: second Frame 8 cycles after the first
    send_partial(7, 1'b1);
    send_frame(16'hCAFE, 16'h0BAD);
    repeat (2) tick();

    // reset mid-word at t+10
    send_partial(9, 1'b0);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("post_rst_sampleL", 32'(bus.sampleL), 32'h0);
    chk("post_rst_sampleR", 32'(bus.sampleR), 32'h0);
    tick();
    chk("hold_sampleL", 32'(bus.sampleL), 32'h0);
    send_frame(16'h0001, 16'hFFFF);
    repeat (3) tick();
    chk("hold_after_L", 32'(bus.sampleL), 32'h0001);
    chk("hold_after_R", 32'(bus.sampleR), 32'hFFFF);

`ifdef SERIAL_RX_SLEEP_EN
    for (int i = 0; i < 4; i++) begin
      send_frame(16'h0000, 16'h0000);
      chk("sleep_zero", 32'(bus.sleep), 32'(i == 3));
      tick();
    end
    send_frame(16'h0001, 16'h0000);
    chk("sleep_wake", 32'(bus.sleep), 32'h0);
    repeat (2) tick();
`endif

    // drain: any word still queued after this budget counts as a failure
    repeat (30) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("err_q_drained", 32'(err_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
